// File: rtl/tlp2mdio_pkg.sv
// Shared types for tlp2mdio: TLP header constant, MDIO command word layout,
// parser/stretcher state encodings.
package tlp2mdio_pkg;

    localparam logic [7:0] MWR32_FMT_TYPE = 8'h40;

    // MDIO command word as seen by the host-clock consumer
    typedef struct packed {
        logic [3:0]  rsvd;
        logic [1:0]  opcode;
        logic [9:0]  addr;
        logic [15:0] wdata;
    } acc_word_t;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_QW1  = 2'd1,
        P_SKIP = 2'd2
    } parse_state_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } stretch_state_t;

    // TRN payload arrives little-endian per DW; the command word is big-endian
    function automatic acc_word_t bswap32(input logic [31:0] d);
        return acc_word_t'({d[7:0], d[15:8], d[23:16], d[31:24]});
    endfunction

endpackage

// File: rtl/tlp2mdio_if.sv
// TRN RX snoop bus plus the MDIO access outputs of tlp2mdio.
// master = RX stream owner / consumer side, slave = tlp2mdio.
interface tlp2mdio_if;

    logic [63:0] trn_rd;
    logic [7:0]  trn_rrem_n;
    logic        trn_rsof_n;
    logic        trn_reof_n;
    logic        trn_rsrc_rdy_n;
    logic        trn_rdst_rdy_n;
    logic        trn_rsrc_dsc_n;
    logic [6:0]  trn_rbar_hit_n;
    logic [31:0] acc_data;
    logic        acc_en;

    modport master (
        output trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n,
               trn_rsrc_rdy_n, trn_rdst_rdy_n, trn_rsrc_dsc_n, trn_rbar_hit_n,
        input  acc_data, acc_en
    );

    modport slave (
        input  trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n,
               trn_rsrc_rdy_n, trn_rdst_rdy_n, trn_rsrc_dsc_n, trn_rbar_hit_n,
        output acc_data, acc_en
    );

endinterface

// File: rtl/tlp2mdio_stretch.sv
// Hold/gap pulse stretcher: one accepted write becomes EN_HOLD cycles of acc_en,
// followed by EN_GAP quiet cycles during which further writes are dropped.
module tlp2mdio_stretch
    import tlp2mdio_pkg::*;
#(
    parameter int EN_HOLD = 16,
    parameter int EN_GAP  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_accept,
    input  logic [31:0] i_data,
    output logic [31:0] o_acc_data,
    output logic        o_acc_en,
    output logic        o_drop
);

    localparam logic [7:0] HOLD_M1 = 8'(EN_HOLD - 1);
    localparam logic [7:0] GAP_M1  = 8'(EN_GAP - 1);

    stretch_state_t r_state, w_state_nxt;
    logic [7:0]     r_cnt, w_cnt_nxt;
    logic           r_en, w_en_nxt;
    logic [31:0]    r_data, w_data_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_en    <= 1'b0;
            r_data  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_en    <= w_en_nxt;
            r_data  <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_en_nxt    = r_en;
        w_data_nxt  = r_data;
        o_drop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_accept) begin
                    w_data_nxt  = i_data;
                    w_en_nxt    = 1'b1;
                    w_cnt_nxt   = HOLD_M1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                o_drop = i_accept;
                if (r_cnt == 8'd0) begin
                    w_en_nxt    = 1'b0;
                    w_cnt_nxt   = GAP_M1;
                    w_state_nxt = S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_GAP: begin
                // the expiry cycle itself still refuses writes
                o_drop = i_accept;
                if (r_cnt == 8'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
                w_en_nxt    = 1'b0;
            end
        endcase
    end

    assign o_acc_data = r_data;
    assign o_acc_en   = r_en;

endmodule

// File: rtl/tlp2mdio.sv
// Snoops the 64-bit TRN RX stream for 1-DW MWr to the MDIO command register
// and hands the payload to the host domain as a stretched strobe.
// Optional drop counter output: define TLP2MDIO_DROP_CNT_EN.
module tlp2mdio
    import tlp2mdio_pkg::*;
#(
    parameter int          BAR_IDX     = 0,
    parameter logic [11:0] MDIO_OFFSET = 12'h030,
    parameter int          EN_HOLD     = 16,
    parameter int          EN_GAP      = 8
) (
    input  logic        trn_clk,
    input  logic        reset,
`ifdef TLP2MDIO_DROP_CNT_EN
    output logic [15:0] drop_cnt,
`endif
    tlp2mdio_if.slave   bus
);

    parse_state_t r_pstate, w_pstate_nxt;
    logic         w_valid;
    logic         w_qw0_match;
    logic         w_addr_match;
    logic         w_accept;
    acc_word_t    w_payload;
    logic [31:0]  w_acc_data;
    logic         w_acc_en;
    logic         w_drop;
    logic         w_unused;

    assign w_valid      = !bus.trn_rsrc_rdy_n && !bus.trn_rdst_rdy_n;
    assign w_qw0_match  = (bus.trn_rd[63:56] == MWR32_FMT_TYPE) &&
                          (bus.trn_rd[41:32] == 10'd1) &&
                          !bus.trn_rbar_hit_n[BAR_IDX];
    assign w_addr_match = (bus.trn_rd[43:34] == MDIO_OFFSET[11:2]);
    assign w_payload    = bswap32(bus.trn_rd[31:0]);

    always_ff @(posedge trn_clk) begin
        if (reset) begin
            r_pstate <= P_IDLE;
        end else begin
            r_pstate <= w_pstate_nxt;
        end
    end

    always_comb begin
        w_pstate_nxt = r_pstate;
        w_accept     = 1'b0;
        if (!bus.trn_rsrc_dsc_n) begin
            w_pstate_nxt = P_IDLE;
        end else if (w_valid) begin
            if (!bus.trn_rsof_n) begin
                // any sof starts a fresh TLP, whatever state we were in
                if (w_qw0_match) begin
                    w_pstate_nxt = P_QW1;
                end else if (bus.trn_reof_n) begin
                    w_pstate_nxt = P_SKIP;
                end else begin
                    w_pstate_nxt = P_IDLE;
                end
            end else begin
                case (r_pstate)
                    P_IDLE: w_pstate_nxt = P_IDLE;
                    P_QW1: begin
                        w_accept     = w_addr_match && !bus.trn_reof_n &&
                                       (bus.trn_rrem_n == 8'h00);
                        w_pstate_nxt = bus.trn_reof_n ? P_SKIP : P_IDLE;
                    end
                    P_SKIP: begin
                        if (!bus.trn_reof_n) begin
                            w_pstate_nxt = P_IDLE;
                        end
                    end
                    default: w_pstate_nxt = P_IDLE;
                endcase
            end
        end
    end

    tlp2mdio_stretch #(
        .EN_HOLD (EN_HOLD),
        .EN_GAP  (EN_GAP)
    ) u_stretch (
        .clk        (trn_clk),
        .rst        (reset),
        .i_accept   (w_accept),
        .i_data     (w_payload),
        .o_acc_data (w_acc_data),
        .o_acc_en   (w_acc_en),
        .o_drop     (w_drop)
    );

    assign bus.acc_data = w_acc_data;
    assign bus.acc_en   = w_acc_en;

`ifdef TLP2MDIO_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge trn_clk) begin
        if (reset) begin
            r_drop_cnt <= 16'd0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    // header bits and BAR bits the match does not look at
    assign w_unused = ^{bus.trn_rd[55:44], bus.trn_rbar_hit_n, w_drop};

endmodule

// File: tb/tb_tlp2mdio.sv
// Directed bench for tlp2mdio: TLP match/reject, stretch timing, drops,
// stalls, discontinue and reset-mid-stretch.
module tb_tlp2mdio;

    logic trn_clk = 1'b0;
    logic reset   = 1'b1;

    always #5 trn_clk = ~trn_clk;

    tlp2mdio_if bus();

`ifdef TLP2MDIO_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    tlp2mdio #(
        .BAR_IDX     (0),
        .MDIO_OFFSET (12'h030),
        .EN_HOLD     (16),
        .EN_GAP      (8)
    ) dut (
        .trn_clk  (trn_clk),
        .reset    (reset),
`ifdef TLP2MDIO_DROP_CNT_EN
        .drop_cnt (drop_cnt),
`endif
        .bus      (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.trn_rd         = 64'd0;
        bus.trn_rrem_n     = 8'h00;
        bus.trn_rsof_n     = 1'b1;
        bus.trn_reof_n     = 1'b1;
        bus.trn_rsrc_rdy_n = 1'b1;
        bus.trn_rdst_rdy_n = 1'b0;
        bus.trn_rsrc_dsc_n = 1'b1;
        bus.trn_rbar_hit_n = 7'h7F;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge trn_clk);
            #1;
        end
    endtask

    task automatic set_beat(input logic sof, input logic eof, input logic [63:0] d,
                            input logic [7:0] rrem, input logic dsc, input logic [6:0] bar);
        bus.trn_rsrc_rdy_n = 1'b0;
        bus.trn_rsof_n     = ~sof;
        bus.trn_reof_n     = ~eof;
        bus.trn_rd         = d;
        bus.trn_rrem_n     = rrem;
        bus.trn_rsrc_dsc_n = ~dsc;
        bus.trn_rbar_hit_n = bar;
    endtask

    task automatic beat(input logic sof, input logic eof, input logic [63:0] d,
                        input logic [7:0] rrem, input logic dsc, input logic [6:0] bar);
        set_beat(sof, eof, d, rrem, dsc, bar);
        tick(1);
        drive_idle();
    endtask

    function automatic logic [63:0] qw0(input logic [7:0] ft, input logic [9:0] len);
        return {ft, 14'h0, len, 32'h0100_000F};
    endfunction

    // 3DW MWr: QW0 header, QW1 = {address, payload}
    task automatic mwr(input logic [31:0] addr, input logic [31:0] payload,
                       input logic [9:0] len, input logic [6:0] bar, input logic dsc_qw1);
        beat(1'b1, 1'b0, qw0(8'h40, len), 8'h00, 1'b0, bar);
        beat(1'b0, 1'b1, {addr, payload}, 8'h00, dsc_qw1, bar);
    endtask

    task automatic watch_en(input int n, output logic seen);
        seen = 1'b0;
        repeat (n) begin
            @(negedge trn_clk);
            if (bus.acc_en === 1'b1) seen = 1'b1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   hi;

        drive_idle();
        reset = 1'b1;
        tick(4);
        @(negedge trn_clk);
        chk("rst_en",   32'(bus.acc_en), 32'd0);
        chk("rst_data", bus.acc_data,    32'd0);
`ifdef TLP2MDIO_DROP_CNT_EN
        chk("rst_drop", 32'(drop_cnt), 32'd0);
`endif
        reset = 1'b0;
        tick(2);

        // basic accepted write and 16-cycle stretch
        mwr(32'h0000_0030, 32'h7856_3412, 10'd1, 7'h7E, 1'b0);
        @(negedge trn_clk);
        chk("t1_en",   32'(bus.acc_en), 32'd1);
        chk("t1_data", bus.acc_data,    32'h1234_5678);
        hi = 0;
        while (bus.acc_en === 1'b1 && hi < 64) begin
            hi++;
            @(negedge trn_clk);
        end
        chk("t1_hold", 32'(hi), 32'd16);
        tick(12);

        // rejected TLPs
        mwr(32'h0000_0034, 32'hDDCC_BBAA, 10'd1, 7'h7E, 1'b0);
        watch_en(20, seen);
        chk("off034_en",   32'(seen), 32'd0);
        chk("off034_data", bus.acc_data, 32'h1234_5678);
        mwr(32'h0000_0030, 32'hDDCC_BBAA, 10'd1, 7'h7F, 1'b0);
        watch_en(20, seen);
        chk("barmiss_en",   32'(seen), 32'd0);
        chk("barmiss_data", bus.acc_data, 32'h1234_5678);
        mwr(32'h0000_0030, 32'hDDCC_BBAA, 10'd2, 7'h7E, 1'b0);
        watch_en(20, seen);
        chk("len2_en",   32'(seen), 32'd0);
        chk("len2_data", bus.acc_data, 32'h1234_5678);

        // drops during hold and on the gap-expiry cycle, then re-accept
        mwr(32'h0000_0030, 32'h4433_2211, 10'd1, 7'h7E, 1'b0);
        @(negedge trn_clk);
        chk("a_en",   32'(bus.acc_en), 32'd1);
        chk("a_data", bus.acc_data,    32'h1122_3344);
        tick(3);
        mwr(32'h0000_0030, 32'hDDCC_BBAA, 10'd1, 7'h7E, 1'b0);
        @(negedge trn_clk);
        chk("b_en",   32'(bus.acc_en), 32'd1);
        chk("b_data", bus.acc_data,    32'h1122_3344);
`ifdef TLP2MDIO_DROP_CNT_EN
        chk("b_drop", 32'(drop_cnt), 32'd1);
`endif
        tick(17);
        mwr(32'h0000_0030, 32'h8877_6655, 10'd1, 7'h7E, 1'b0);
        @(negedge trn_clk);
        chk("c_en",   32'(bus.acc_en), 32'd0);
        chk("c_data", bus.acc_data,    32'h1122_3344);
`ifdef TLP2MDIO_DROP_CNT_EN
        chk("c_drop", 32'(drop_cnt), 32'd2);
`endif
        mwr(32'h0000_0030, 32'h0DF0_ADDE, 10'd1, 7'h7E, 1'b0);
        @(negedge trn_clk);
        chk("d_en",   32'(bus.acc_en), 32'd1);
        chk("d_data", bus.acc_data,    32'hDEAD_F00D);
        tick(30);

        // source stall between QW0 and QW1, plus a beat the sink refuses
        beat(1'b1, 1'b0, qw0(8'h40, 10'd1), 8'h00, 1'b0, 7'h7E);
        set_beat(1'b1, 1'b1, {32'h0000_0030, 32'hFFFF_FFFF}, 8'h00, 1'b0, 7'h7E);
        bus.trn_rsrc_rdy_n = 1'b1;
        tick(3);
        set_beat(1'b0, 1'b1, {32'h0000_0030, 32'hEEEE_EEEE}, 8'h00, 1'b0, 7'h7E);
        bus.trn_rdst_rdy_n = 1'b1;
        tick(1);
        drive_idle();
        beat(1'b0, 1'b1, {32'h0000_0030, 32'h0403_0201}, 8'h00, 1'b0, 7'h7E);
        @(negedge trn_clk);
        chk("stall_en",   32'(bus.acc_en), 32'd1);
        chk("stall_data", bus.acc_data,    32'h0102_0304);
        tick(30);

        // discontinue on QW1, then a clean write
        mwr(32'h0000_0030, 32'h0C0B_0A09, 10'd1, 7'h7E, 1'b1);
        watch_en(20, seen);
        chk("dsc_en",   32'(seen), 32'd0);
        chk("dsc_data", bus.acc_data, 32'h0102_0304);
        mwr(32'h0000_0030, 32'h1413_1211, 10'd1, 7'h7E, 1'b0);
        @(negedge trn_clk);
        chk("post_dsc_en",   32'(bus.acc_en), 32'd1);
        chk("post_dsc_data", bus.acc_data,    32'h1112_1314);

        // reset at hold cycle 7 while a new TLP starts; its tail must be ignored
        tick(6);
        reset = 1'b1;
        set_beat(1'b1, 1'b0, qw0(8'h40, 10'd1), 8'h00, 1'b0, 7'h7E);
        tick(1);
        reset = 1'b0;
        drive_idle();
        @(negedge trn_clk);
        chk("rst_mid_en",   32'(bus.acc_en), 32'd0);
        chk("rst_mid_data", bus.acc_data,    32'd0);
`ifdef TLP2MDIO_DROP_CNT_EN
        chk("rst_mid_drop", 32'(drop_cnt), 32'd0);
`endif
        beat(1'b0, 1'b1, {32'h0000_0030, 32'h5555_5555}, 8'h00, 1'b0, 7'h7E);
        watch_en(20, seen);
        chk("tail_en",   32'(seen), 32'd0);
        chk("tail_data", bus.acc_data, 32'd0);

        // 4DW MWr back-to-back with a matching 3DW write
        beat(1'b1, 1'b0, qw0(8'h60, 10'd1), 8'h00, 1'b0, 7'h7E);
        beat(1'b0, 1'b0, {32'h0000_0000, 32'h0000_0030}, 8'h00, 1'b0, 7'h7E);
        beat(1'b0, 1'b1, {32'hEFBE_ADDE, 32'h0000_0000}, 8'h0F, 1'b0, 7'h7E);
        mwr(32'h0000_0030, 32'h3C2B_1A09, 10'd1, 7'h7E, 1'b0);
        @(negedge trn_clk);
        chk("b2b_en",   32'(bus.acc_en), 32'd1);
        chk("b2b_data", bus.acc_data,    32'h091A_2B3C);
        tick(30);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/tlp2mdio.md
Name: tlp2mdio

Overview:
- Upstream feeder of the MDIO host-interface stage.
- Snoops the Virtex-5 PCIe TRN RX stream (64-bit) for 1-DW posted memory writes to the MDIO command register in a chosen BAR.
- Latches the 32-bit payload onto acc_data and raises acc_en as a stretched level, so the host-clock consumer catches it through its 2-flop synchroniser.
- Runs entirely in the PCIe user clock domain.

Parameters:
- BAR_IDX, 0: trn_rbar_hit_n bit that must be low (active) for a match.
- MDIO_OFFSET, 12'h030: byte offset of the MDIO command register in the BAR; compared on address bits [11:2].
- EN_HOLD, 16: trn_clk cycles acc_en stays high per accepted write (range 4..255).
- EN_GAP, 8: trn_clk cycles acc_en stays low after a stretch before another write can be accepted (range 1..255).

Ports:
- trn_clk  in  1  PCIe user clock.
- reset  in  1  synchronous, active-high.
- trn_rd  in  64  RX data; DW0 in [63:32].
- trn_rrem_n  in  8  RX remainder; 8'h00 = both DWs valid, 8'h0F = upper DW only.
- trn_rsof_n  in  1  start of frame, active-low.
- trn_reof_n  in  1  end of frame, active-low.
- trn_rsrc_rdy_n  in  1  source ready, active-low.
- trn_rdst_rdy_n  in  1  destination ready as driven by the RX owner; snooped only.
- trn_rsrc_dsc_n  in  1  source discontinue, active-low.
- trn_rbar_hit_n  in  7  BAR hit, active-low.
- acc_data  out  32  MDIO command word: [27:26] opcode, [25:16] addr, [15:0] wr data.
- acc_en  out  1  stretched access strobe.

Behaviour:
- Beat valid = !trn_rsrc_rdy_n & !trn_rdst_rdy_n. All state advances only on valid beats, except reset and the stretch counter.
- Parser FSM:
  - P_IDLE:
    - Valid beat with sof=0 checks QW0: trn_rd[63:56]==8'h40 (MWr, 3DW, with data), trn_rd[41:32]==10'd1, trn_rbar_hit_n[BAR_IDX]==0.
    - Match -> P_QW1.
    - Mismatch and eof not on this beat -> P_SKIP; otherwise stay in P_IDLE.
  - P_QW1:
    - On a valid beat: address trn_rd[63:32] bits [11:2] == MDIO_OFFSET[11:2], eof=0, rrem_n==8'h00, dsc_n=1 -> accept pulse.
    - Payload = trn_rd[31:0] byte-swapped: {[7:0],[15:8],[23:16],[31:24]}.
    - Always -> P_IDLE afterwards. A non-terminating beat here means a malformed TLP -> P_SKIP.
  - P_SKIP: stays until a valid beat with eof=0 -> P_IDLE.
  - trn_rsrc_dsc_n=0 in any state -> P_IDLE next cycle; no accept that cycle.
  - sof seen while in P_QW1 or P_SKIP: treat as a new TLP; re-evaluate as P_IDLE would.
- Stretch FSM:
  - S_IDLE: on accept, latch acc_data, acc_en<=1, cnt<=EN_HOLD-1 -> S_HOLD. acc_en rises the cycle after the eof beat (latency 1).
  - S_HOLD: cnt decrements; at 0, acc_en<=0, cnt<=EN_GAP-1 -> S_GAP.
  - S_GAP: cnt decrements; at 0 -> S_IDLE.
  - Accept while in S_HOLD/S_GAP: write dropped; acc_data unchanged.
  - An accept in the same cycle that S_GAP expires is dropped. Only S_IDLE accepts.
- acc_data is held until the next accepted write and is never modified while acc_en=1.
- Reset, including mid-TLP or mid-stretch: acc_en=0, acc_data=0, both FSMs idle, counters 0. A TLP in flight during reset is ignored through its eof.

Optional Feature:
- TLP2MDIO_DROP_CNT_EN:
  - Defined: extra output drop_cnt [15:0], reset 0. Increments by 1 per dropped accept and saturates at 16'hFFFF.
  - Undefined: port and counter absent; drops are silent.

Decomposition:
- Shared package: TLP fmt/type constant MWR32_FMT_TYPE=8'h40, the acc_data field positions (opcode/addr/data slices), and parser/stretch state encodings.
- Natural sub-module: tlp2mdio_stretch (counter-based hold/gap pulse stretcher, parameters EN_HOLD/EN_GAP). The parser stays inline.

Test Plan:
- MWr 3DW, len 1, BAR0, addr 0x...030, payload bytes 0x78563412 -> acc_data=32'h12345678 one cycle after eof; acc_en high exactly 16 cycles.
- Same TLP to offset 0x034, or with bar_hit_n[0]=1, or len=2 -> acc_en stays 0; acc_data unchanged.
- Second matching write 5 cycles after acc_en rises -> dropped; acc_data keeps the first value; drop_cnt=1 when enabled. Third write after 16+8 cycles -> accepted.
- trn_rsrc_rdy_n deasserted for 3 cycles between QW0 and QW1 -> still accepted; trn_rsrc_dsc_n=0 on QW1 -> not accepted, parser returns to idle.
- reset asserted at cycle 7 of the hold -> acc_en=0 and acc_data=0 the next cycle. An unrelated 4DW MWr followed back-to-back by a matching write -> only the second is accepted.
